// File: rtl/inventory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inventory_arbiter
// Description : Per-slot item-count store for the vending machine. Accesses
//               from three requesters are serialised into a fixed
//               grant/execute/respond sequence:
//                 admin   - write a slot count (values above MAX_CNT are clamped)
//                 vend    - decrement a slot count if it is nonzero
//                 display - read a slot count
//               A running count of sold-out slots is also kept.
// Ports       : clk, rst_n (async, active-low)
//               adm_req/adm_slot/adm_wdata -> adm_ack/adm_ok
//               vend_req/vend_slot         -> vend_ack/vend_ok
//               rd_req/rd_slot             -> rd_ack/rd_data
//               busy        : FSM is not idle
//               empty_slots : number of valid slots whose count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module inventory_arbiter #(
  parameter int SLOTS    = 69,
  parameter int IDX_W    = 7,
  parameter int CNT_W    = 4,
  parameter int MAX_CNT  = 9,
  parameter int INIT_CNT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adm_req,
  input  logic [IDX_W-1:0] adm_slot,
  input  logic [CNT_W-1:0] adm_wdata,
  output logic             adm_ack,
  output logic             adm_ok,
  input  logic             vend_req,
  input  logic [IDX_W-1:0] vend_slot,
  output logic             vend_ack,
  output logic             vend_ok,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_slot,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic [IDX_W-1:0] empty_slots
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OP_ADM = 2'd0, OP_VEND = 2'd1, OP_RD = 2'd2} op_t;

  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);
  localparam logic [IDX_W:0]   SLOT_LIM = (IDX_W+1)'(SLOTS);
  localparam logic [IDX_W-1:0] EMPTY_RST = (INIT_CNT == 0) ? IDX_W'(SLOTS) : '0;
  localparam logic [IDX_W-1:0] EMPTY_MAX = IDX_W'(SLOTS);

  state_t           state;
  op_t              op;
  logic [IDX_W-1:0] op_slot;
  logic [CNT_W-1:0] op_wdata;
  logic             rr_last_rd;   // 1: last vend/rd grant went to rd
  logic [CNT_W-1:0] cnt [SLOTS];

  logic             slot_ok;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] new_val;
  logic             wr;
  logic             vend_win;

  assign slot_ok = ({1'b0, op_slot} < SLOT_LIM);
  // Out-of-range slots never touch the array; they read as zero.
  assign cur     = slot_ok ? cnt[op_slot] : '0;
  // Vend beats rd on a tie unless vend was the previous vend/rd grant.
  assign vend_win = vend_req && (!rd_req || rr_last_rd);

  always_comb begin
    new_val = cur;
    wr      = 1'b0;
    case (op)
      OP_ADM: begin
        new_val = (op_wdata > MAX_VAL) ? MAX_VAL : op_wdata;
        wr      = slot_ok;
      end
      OP_VEND: begin
        new_val = cur - 1'b1;
        wr      = slot_ok && (cur != '0);
      end
      default: begin
        new_val = cur;
        wr      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) cnt[i] <= INIT_VAL;
      state       <= IDLE;
      op          <= OP_ADM;
      op_slot     <= '0;
      op_wdata    <= '0;
      rr_last_rd  <= 1'b1;
      adm_ack     <= 1'b0;
      adm_ok      <= 1'b0;
      vend_ack    <= 1'b0;
      vend_ok     <= 1'b0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
      busy        <= 1'b0;
      empty_slots <= EMPTY_RST;
    end else begin
      // Acks and ok flags are single-cycle pulses by default.
      adm_ack  <= 1'b0;
      adm_ok   <= 1'b0;
      vend_ack <= 1'b0;
      vend_ok  <= 1'b0;
      rd_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (adm_req) begin
            op       <= OP_ADM;
            op_slot  <= adm_slot;
            op_wdata <= adm_wdata;
            state    <= EXEC;
            busy     <= 1'b1;
          end else if (vend_win) begin
            op         <= OP_VEND;
            op_slot    <= vend_slot;
            rr_last_rd <= 1'b0;
            state      <= EXEC;
            busy       <= 1'b1;
          end else if (rd_req) begin
            op         <= OP_RD;
            op_slot    <= rd_slot;
            rr_last_rd <= 1'b1;
            state      <= EXEC;
            busy       <= 1'b1;
          end
        end
        EXEC: begin
          state <= RESP;
          if (wr) begin
            cnt[op_slot] <= new_val;
            if ((cur != '0) && (new_val == '0) && (empty_slots < EMPTY_MAX))
              empty_slots <= empty_slots + 1'b1;
            else if ((cur == '0) && (new_val != '0) && (empty_slots != '0))
              empty_slots <= empty_slots - 1'b1;
          end
          // Acks are registered here so they are high throughout RESP.
          case (op)
            OP_ADM: begin
              adm_ack <= 1'b1;
              adm_ok  <= slot_ok && (op_wdata <= MAX_VAL);
            end
            OP_VEND: begin
              vend_ack <= 1'b1;
              vend_ok  <= wr;
            end
            default: begin
              rd_ack  <= 1'b1;
              rd_data <= cur;
            end
          endcase
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/inventory_arbiter.md
Name: inventory_arbiter

Overview:
- Owns the per-slot item-count store of the vending machine.
- Serialises access to it from three requesters:
  - admin restock path: write count
  - user vend path: decrement count
  - display path: read count
- Each access is a fixed 3-cycle grant/execute/respond sequence with a one-cycle ack pulse.
- Also maintains a running count of sold-out slots for the front panel.

Parameters:
SLOTS, 69, number of item slots (valid indices 0..SLOTS-1)
IDX_W, 7, slot index width
CNT_W, 4, per-slot count width
MAX_CNT, 9, maximum storable count
INIT_CNT, 9, count loaded into every slot on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
adm_req  in  1  admin write request (level, held until adm_ack)
adm_slot  in  IDX_W  admin target slot
adm_wdata  in  CNT_W  admin new count
adm_ack  out  1  one-cycle pulse: admin op complete
adm_ok  out  1  valid with adm_ack: 1 = written unclamped
vend_req  in  1  vend decrement request (level, held until vend_ack)
vend_slot  in  IDX_W  vend target slot
vend_ack  out  1  one-cycle pulse: vend op complete
vend_ok  out  1  valid with vend_ack: 1 = item dispensed (count decremented)
rd_req  in  1  display read request (level, held until rd_ack)
rd_slot  in  IDX_W  read target slot
rd_ack  out  1  one-cycle pulse: read complete
rd_data  out  CNT_W  valid with rd_ack: slot count
busy  out  1  high whenever FSM not in IDLE
empty_slots  out  IDX_W  number of valid slots whose count is 0

Behaviour:

Reset (async, rst_n=0):
- All counts = INIT_CNT.
- FSM = IDLE.
- All acks, oks, rd_data, busy = 0.
- empty_slots = (INIT_CNT==0 ? SLOTS : 0).
- rr_last = rd, so vend wins the first tie.
- Reset mid-operation aborts the op: no write, no ack.

FSM states: IDLE, EXEC, RESP.

IDLE:
- If any request is high, grant one:
  - adm_req has fixed highest priority.
  - vend_req vs rd_req is round-robin via rr_last: the one not granted last wins a tie. rr_last updates only on vend/rd grants.
- On grant:
  - Latch the op type, slot, and wdata.
  - Go to EXEC.
- busy=1 from the following cycle.

EXEC:
- Read the latched slot.
- Compute the result and the ok flag.
- Perform the write.
- Go to RESP.

RESP:
- Assert exactly one ack for one cycle, with ok/rd_data valid in the same cycle.
- Go to IDLE.

Latency and handshake:
- Request sampled in IDLE at edge N; ack high during cycle N+2.
- Back-to-back ops start every 3 cycles.
- Requesters must deassert req at the edge ending the ack cycle. A req still high in IDLE is treated as a new request.
- A req dropped after grant does not cancel the op; the ack still pulses.
- Latched slot/wdata are immune to input changes after grant.
- rd_data holds its last value between acks; oks are 0 outside ack cycles.

Vend:
- slot < SLOTS and count > 0: count -= 1, vend_ok = 1.
- count == 0 or slot >= SLOTS: no change, vend_ok = 0.

Admin:
- slot < SLOTS, wdata <= MAX_CNT: count = wdata, adm_ok = 1.
- wdata > MAX_CNT: count = MAX_CNT (clamped), adm_ok = 0.
- slot >= SLOTS: no write, adm_ok = 0.

Read:
- rd_data = count, or 0 if slot >= SLOTS.

empty_slots:
- Updated in EXEC with the write.
- +1 when a count goes nonzero -> 0; -1 when it goes 0 -> nonzero.
- Unchanged on 0 -> 0.
- Never exceeds SLOTS and never underflows.

Simultaneous requests: only one op is in flight at a time. Losers stay pending and are served in later IDLE visits. Admin can starve the others by design; vend/rd cannot starve each other.

Test Plan:
- Reset, then rd_req slot 5 -> rd_ack at cycle +2, rd_data=9, busy high for 2 cycles, empty_slots=0.
- Vend slot 12 ten times -> first nine vend_ok=1 with count 8..0, tenth vend_ok=0; empty_slots 0 -> 1 after ninth.
- adm_req slot 12 wdata 15 -> adm_ok=0, rd slot 12 returns 9, empty_slots back to 0; adm wdata 0 -> adm_ok=1, empty_slots=1.
- adm_req, vend_req, rd_req all raised and held same cycle -> grant order adm, vend, rd (acks at +2, +5, +8); repeat with vend/rd only, held -> vend, rd, vend, rd alternation.
- vend_req slot 69 and rd_req slot 100 -> vend_ok=0, rd_data=0, no count or empty_slots change.
- Assert rst_n=0 during EXEC of a vend on slot 3 -> no ack, FSM IDLE, slot 3 reads 9 after release.
